// File: rtl/brcomp_iter_if.sv
// Execute-stage handshake bundle for the iterative branch comparator:
// operand/op request side plus the registered result side.
interface brcomp_iter_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] rs1_data_i;
    logic [WIDTH-1:0] rs2_data_i;
    logic [2:0]       br_op_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             br_less_o;
    logic             br_equal_o;
    logic             br_taken_o;
    logic             br_illegal_o;

    // Issuing side: presents operands and consumes results.
    modport master (
        output in_valid_i, rs1_data_i, rs2_data_i, br_op_i, out_ready_i,
        input  in_ready_o, out_valid_o, br_less_o, br_equal_o, br_taken_o, br_illegal_o
    );

    // Comparator side.
    modport slave (
        input  in_valid_i, rs1_data_i, rs2_data_i, br_op_i, out_ready_i,
        output in_ready_o, out_valid_o, br_less_o, br_equal_o, br_taken_o, br_illegal_o
    );
endinterface

// File: rtl/brcomp_iter.sv
// Multi-cycle RISC-V branch comparator. Operands are compared one DIGIT-bit
// digit per cycle from the most significant digit down; signed compares are
// turned into unsigned ones by flipping the operand sign bits on capture.
module brcomp_iter #(
    parameter int WIDTH      = 32,
    parameter int DIGIT      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    output logic         busy_o,
    brcomp_iter_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NDIG - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMP  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
            $error("brcomp_iter: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    // Offset-binary mapping: flipping the sign bit makes unsigned order match signed order.
    function automatic logic [WIDTH-1:0] offset_bin(input logic [WIDTH-1:0] v, input logic signed_mode);
        offset_bin = v ^ {signed_mode, {(WIDTH-1){1'b0}}};
    endfunction

    function automatic logic op_illegal(input logic [2:0] op);
        op_illegal = (op == 3'b010) || (op == 3'b011);
    endfunction

    function automatic logic op_taken(input logic [2:0] op, input logic less, input logic eq);
        case (op)
            3'b000:  op_taken = eq;
            3'b001:  op_taken = ~eq;
            3'b100:  op_taken = less;
            3'b101:  op_taken = ~less;
            3'b110:  op_taken = less;
            3'b111:  op_taken = ~less;
            default: op_taken = 1'b0;
        endcase
    endfunction

    logic [1:0]       state_r, state_nxt_s;
    logic [WIDTH-1:0] a_r, b_r;
    logic [2:0]       op_r;
    logic [IDXW-1:0]  idx_r, idx_nxt_s;
    logic             less_r, less_nxt_s;
    logic             eq_r, eq_nxt_s;
    logic             decided_r, decided_nxt_s;
    logic             out_valid_r, out_less_r, out_equal_r, out_taken_r, out_illegal_r, busy_r;
    logic [DIGIT-1:0] a_d_s, b_d_s;
    logic             lt_s, gt_s, diff_s, accept_s, in_ready_s, done_nxt_s;

    assign in_ready_s = (state_r == IDLE) & ~flush_i;
    assign accept_s   = in_ready_s & bus.in_valid_i;
    assign a_d_s      = a_r[int'(idx_r) * DIGIT +: DIGIT];
    assign b_d_s      = b_r[int'(idx_r) * DIGIT +: DIGIT];
    assign lt_s       = (a_d_s < b_d_s);
    assign gt_s       = (a_d_s > b_d_s);
    assign diff_s     = ~decided_r & (lt_s | gt_s);
    assign done_nxt_s = (state_nxt_s == DONE);

    // Next-state and compare-result update for the digit-serial FSM.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        less_nxt_s    = less_r;
        eq_nxt_s      = eq_r;
        decided_nxt_s = decided_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s   = CMP;
                    idx_nxt_s     = IDX_TOP;
                    less_nxt_s    = 1'b0;
                    eq_nxt_s      = 1'b1;
                    decided_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CMP: begin
                if (diff_s) begin
                    less_nxt_s    = lt_s;
                    eq_nxt_s      = 1'b0;
                    decided_nxt_s = 1'b1;
                end else begin
                    decided_nxt_s = decided_r;
                end
                if ((idx_r == {IDXW{1'b0}}) || ((EARLY_EXIT != 0) && diff_s)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CMP;
                    idx_nxt_s   = idx_r - {{(IDXW-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                if (bus.out_ready_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
        if (flush_i) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State, operand capture and compare bookkeeping.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            op_r      <= 3'b000;
            idx_r     <= {IDXW{1'b0}};
            less_r    <= 1'b0;
            eq_r      <= 1'b0;
            decided_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            less_r    <= less_nxt_s;
            eq_r      <= eq_nxt_s;
            decided_r <= decided_nxt_s;
            if (accept_s) begin
                a_r  <= offset_bin(bus.rs1_data_i, ~bus.br_op_i[1]);
                b_r  <= offset_bin(bus.rs2_data_i, ~bus.br_op_i[1]);
                op_r <= bus.br_op_i;
            end
        end
    end

    // Registered outputs; results are forced to zero outside DONE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_r   <= 1'b0;
            out_less_r    <= 1'b0;
            out_equal_r   <= 1'b0;
            out_taken_r   <= 1'b0;
            out_illegal_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            out_valid_r   <= done_nxt_s;
            out_less_r    <= done_nxt_s & less_nxt_s;
            out_equal_r   <= done_nxt_s & eq_nxt_s;
            out_taken_r   <= done_nxt_s & ~op_illegal(op_r) & op_taken(op_r, less_nxt_s, eq_nxt_s);
            out_illegal_r <= done_nxt_s & op_illegal(op_r);
            busy_r        <= (state_nxt_s != IDLE);
        end
    end

    assign bus.in_ready_o   = in_ready_s;
    assign bus.out_valid_o  = out_valid_r;
    assign bus.br_less_o    = out_less_r;
    assign bus.br_equal_o   = out_equal_r;
    assign bus.br_taken_o   = out_taken_r;
    assign bus.br_illegal_o = out_illegal_r;
    assign busy_o           = busy_r;
endmodule

// File: tb/tb_brcomp_iter.sv
// Directed bench for brcomp_iter: one early-exit instance and one
// fixed-latency instance, with hand-computed expected results.
module tb_brcomp_iter;
    logic clk = 1'b0;
    logic rst_n;
    logic flush0, flush1;
    logic busy0, busy1;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    brcomp_iter_if #(.WIDTH(32)) bus0 ();
    brcomp_iter_if #(.WIDTH(32)) bus1 ();

    brcomp_iter #(.WIDTH(32), .DIGIT(8), .EARLY_EXIT(1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush0), .busy_o(busy0), .bus(bus0.slave)
    );
    brcomp_iter #(.WIDTH(32), .DIGIT(8), .EARLY_EXIT(0)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush1), .busy_o(busy1), .bus(bus1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] res(input bit sel);
        if (sel) res = {bus1.out_valid_o, bus1.br_less_o, bus1.br_equal_o, bus1.br_taken_o, bus1.br_illegal_o};
        else     res = {bus0.out_valid_o, bus0.br_less_o, bus0.br_equal_o, bus0.br_taken_o, bus0.br_illegal_o};
    endfunction

    task automatic accept(input bit sel, input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if (sel) begin
            bus1.in_valid_i = 1'b1; bus1.br_op_i = op; bus1.rs1_data_i = a; bus1.rs2_data_i = b;
            bus1.out_ready_i = 1'b1;
        end else begin
            bus0.in_valid_i = 1'b1; bus0.br_op_i = op; bus0.rs1_data_i = a; bus0.rs2_data_i = b;
            bus0.out_ready_i = 1'b1;
        end
        #1;
        chk({name, ".in_ready"}, {31'd0, sel ? bus1.in_ready_o : bus0.in_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        bus0.in_valid_i = 1'b0;
        bus1.in_valid_i = 1'b0;
    endtask

    // Called 1 time unit after the accept edge; counts edges until out_valid.
    task automatic collect(input bit sel, input string name, input int exp_lat,
                           input logic el, input logic ee, input logic et, input logic ei);
        int lat = 1;
        logic [4:0] r;
        r = res(sel);
        while (!r[4] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            r = res(sel);
        end
        chk({name, ".latency"}, lat, exp_lat);
        chk({name, ".result"}, {27'd0, r}, {27'd0, 1'b1, el, ee, et, ei});
        @(posedge clk);
        #1;
        r = res(sel);
        chk({name, ".cleared"}, {27'd0, r}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
        bus0.in_valid_i = 1'b0; bus0.br_op_i = 3'b000; bus0.rs1_data_i = 32'd0; bus0.rs2_data_i = 32'd0;
        bus0.out_ready_i = 1'b0;
        bus1.in_valid_i = 1'b0; bus1.br_op_i = 3'b000; bus1.rs1_data_i = 32'd0; bus1.rs2_data_i = 32'd0;
        bus1.out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.outputs", {26'd0, res(1'b0), busy0}, 32'd0);
        chk("reset.outputs_ee0", {26'd0, res(1'b1), busy1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset.in_ready", {31'd0, bus0.in_ready_o}, 32'd1);

        // Signed and unsigned basics, early exit at the top digit.
        accept(1'b0, "blt_neg1_1", 3'b100, 32'hFFFF_FFFF, 32'h0000_0001);
        collect(1'b0, "blt_neg1_1", 2, 1'b1, 1'b0, 1'b1, 1'b0);
        accept(1'b0, "bltu_ff_1", 3'b110, 32'hFFFF_FFFF, 32'h0000_0001);
        collect(1'b0, "bltu_ff_1", 2, 1'b0, 1'b0, 1'b0, 1'b0);
        accept(1'b0, "bgeu_ff_1", 3'b111, 32'hFFFF_FFFF, 32'h0000_0001);
        collect(1'b0, "bgeu_ff_1", 2, 1'b0, 1'b0, 1'b1, 1'b0);
        // Equal operands examine every digit; low-digit difference too.
        accept(1'b0, "beq_equal", 3'b000, 32'h1234_5678, 32'h1234_5678);
        collect(1'b0, "beq_equal", 5, 1'b0, 1'b1, 1'b1, 1'b0);
        accept(1'b0, "bne_low", 3'b001, 32'h0000_00FF, 32'h0000_00FE);
        collect(1'b0, "bne_low", 5, 1'b0, 1'b0, 1'b1, 1'b0);
        // Most-negative vs most-positive resolves at the MSB digit.
        accept(1'b0, "bge_min_max", 3'b101, 32'h8000_0000, 32'h7FFF_FFFF);
        collect(1'b0, "bge_min_max", 2, 1'b1, 1'b0, 1'b0, 1'b0);
        // Difference in digit 1: three digits examined.
        accept(1'b0, "blt_digit1", 3'b100, 32'h0000_1000, 32'h0000_2000);
        collect(1'b0, "blt_digit1", 4, 1'b1, 1'b0, 1'b1, 1'b0);
        // Fixed-latency instance.
        accept(1'b1, "ee0_blt", 3'b100, 32'hFFFF_FFFF, 32'h0000_0001);
        collect(1'b1, "ee0_blt", 5, 1'b1, 1'b0, 1'b1, 1'b0);

        // Backpressure: result held, second request waits.
        @(negedge clk);
        bus0.in_valid_i = 1'b1; bus0.br_op_i = 3'b100;
        bus0.rs1_data_i = 32'hFFFF_FFFF; bus0.rs2_data_i = 32'h0000_0001;
        bus0.out_ready_i = 1'b0;
        @(posedge clk);
        #1;
        bus0.br_op_i = 3'b000; bus0.rs1_data_i = 32'd5; bus0.rs2_data_i = 32'd5;
        chk("bp.busy", {31'd0, busy0}, 32'd1);
        chk("bp.in_ready_cmp", {31'd0, bus0.in_ready_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("bp.first_valid", {27'd0, res(1'b0)}, {27'd0, 5'b11010});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp.hold", {27'd0, res(1'b0)}, {27'd0, 5'b11010});
            chk("bp.hold_in_ready", {31'd0, bus0.in_ready_o}, 32'd0);
        end
        @(negedge clk);
        bus0.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("bp.released", {26'd0, res(1'b0), busy0}, 32'd0);
        chk("bp.in_ready_idle", {31'd0, bus0.in_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        bus0.in_valid_i = 1'b0;
        chk("bp.second_accepted", {31'd0, busy0}, 32'd1);
        collect(1'b0, "bp.second", 5, 1'b0, 1'b1, 1'b1, 1'b0);

        // Flush in the second compare cycle.
        accept(1'b0, "flush_op", 3'b000, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        chk("flush.cmp2_busy", {31'd0, busy0}, 32'd1);
        @(negedge clk);
        flush0 = 1'b1;
        #1;
        chk("flush.in_ready", {31'd0, bus0.in_ready_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("flush.idle", {26'd0, res(1'b0), busy0}, 32'd0);
        @(negedge clk);
        flush0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("flush.no_result", {27'd0, res(1'b0)}, 32'd0);
        end
        // Flush together with a request in IDLE: not accepted.
        @(negedge clk);
        bus0.in_valid_i = 1'b1; bus0.br_op_i = 3'b000; bus0.rs1_data_i = 32'd1; bus0.rs2_data_i = 32'd1;
        flush0 = 1'b1;
        @(posedge clk);
        #1;
        chk("flush.idle_reject", {31'd0, busy0}, 32'd0);
        @(negedge clk);
        bus0.in_valid_i = 1'b0;
        flush0 = 1'b0;
        accept(1'b0, "post_flush_bltu", 3'b110, 32'd1, 32'd2);
        collect(1'b0, "post_flush_bltu", 5, 1'b1, 1'b0, 1'b1, 1'b0);
        accept(1'b0, "illegal_010", 3'b010, 32'd5, 32'd5);
        collect(1'b0, "illegal_010", 5, 1'b0, 1'b1, 1'b0, 1'b1);

        // Reset mid-operation.
        accept(1'b0, "rst_mid", 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid.outputs", {26'd0, res(1'b0), busy0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_mid.in_ready", {31'd0, bus0.in_ready_o}, 32'd1);
        accept(1'b0, "after_rst", 3'b100, 32'hFFFF_FFFF, 32'h0000_0001);
        collect(1'b0, "after_rst", 2, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
